// File: rtl/srl_fifo_reader.sv
// First-word-fall-through FIFO over an SRL-style shift array: data shifts in at
// entry 0 and the head is read by address, so only the count moves on a read.
module srl_fifo_reader #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 5,
  parameter int AF_THRESH = 28
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [WIDTH-1:0]  WR_DATA,
  output logic              FULL,
  output logic              ALMOST_FULL,
  input  logic              RD_EN,
  output logic [WIDTH-1:0]  RD_DATA,
  output logic              EMPTY,
  output logic [ADDR_W:0]   LEVEL,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_LVL    = (ADDR_W+1)'(AF_THRESH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf_q;
  logic              unf_q;

  // Flags depend on cnt only, so acceptance always sees pre-edge state.
  assign EMPTY       = (cnt == '0);
  assign FULL        = (cnt == DEPTH_LVL);
  assign ALMOST_FULL = (cnt >= AF_LVL);
  assign LEVEL       = cnt;
  assign OVERFLOW    = ovf_q;
  assign UNDERFLOW   = unf_q;

  assign wr_acc = WR_EN & ~FULL;
  assign rd_acc = RD_EN & ~EMPTY;

  // At cnt == DEPTH the low bits wrap to zero and cnt-1 lands on DEPTH-1.
  assign rd_addr = ADDR_W'(cnt - 1'b1);
  assign RD_DATA = EMPTY ? '0 : mem[rd_addr];

  // Data storage: no reset; stale words are unreachable once cnt is cleared.
  always_ff @(posedge CLK) begin
    if (!RST && wr_acc) begin
      mem[0] <= WR_DATA;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Control: occupancy and sticky error flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_acc && !rd_acc) begin
        cnt <= cnt + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        cnt <= cnt - 1'b1;
      end
      if (WR_EN && FULL) begin
        ovf_q <= 1'b1;
      end
      if (RD_EN && EMPTY) begin
        unf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_srl_fifo_reader.sv
// Directed bench for srl_fifo_reader: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_srl_fifo_reader;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 5;

  logic              CLK = 1'b0;
  logic              RST;
  logic              WR_EN;
  logic [WIDTH-1:0]  WR_DATA;
  logic              FULL;
  logic              ALMOST_FULL;
  logic              RD_EN;
  logic [WIDTH-1:0]  RD_DATA;
  logic              EMPTY;
  logic [ADDR_W:0]   LEVEL;
  logic              OVERFLOW;
  logic              UNDERFLOW;

  int n_cmp = 0;
  int n_err = 0;

  srl_fifo_reader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AF_THRESH(28)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .FULL(FULL),
    .ALMOST_FULL(ALMOST_FULL), .RD_EN(RD_EN), .RD_DATA(RD_DATA), .EMPTY(EMPTY),
    .LEVEL(LEVEL), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    WR_EN = 1'b1;
    WR_DATA = d;
    step();
    WR_EN = 1'b0;
  endtask

  initial begin
    RST = 1'b1; WR_EN = 1'b0; RD_EN = 1'b0; WR_DATA = '0;
    step();
    RST = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("rst_empty", 32'(EMPTY), 1);
    check("rst_full", 32'(FULL), 0);
    check("rst_af", 32'(ALMOST_FULL), 0);
    check("rst_level", 32'(LEVEL), 0);
    check("rst_rdata", 32'(RD_DATA), 0);
    check("rst_ovf", 32'(OVERFLOW), 0);
    check("rst_unf", 32'(UNDERFLOW), 0);

    // Three writes, then three reads.
    WR_EN = 1'b1; WR_DATA = 8'h11;
    step();
    check("fwft_first", 32'(RD_DATA), 32'h11);
    check("fwft_level1", 32'(LEVEL), 1);
    check("fwft_not_empty", 32'(EMPTY), 0);
    WR_DATA = 8'h22; step();
    WR_DATA = 8'h33; step();
    WR_EN = 1'b0;
    check("w3_level", 32'(LEVEL), 3);
    RD_EN = 1'b1;
    check("rd0_data", 32'(RD_DATA), 32'h11); step();
    check("rd0_level", 32'(LEVEL), 2);
    check("rd1_data", 32'(RD_DATA), 32'h22); step();
    check("rd1_level", 32'(LEVEL), 1);
    check("rd2_data", 32'(RD_DATA), 32'h33); step();
    RD_EN = 1'b0;
    check("rd2_level", 32'(LEVEL), 0);
    check("rd_empty", 32'(EMPTY), 1);
    check("rd_rdata0", 32'(RD_DATA), 0);
    check("rd_no_unf", 32'(UNDERFLOW), 0);

    // Fill to DEPTH, overflow attempt, drain.
    WR_EN = 1'b1;
    for (int i = 0; i < 32; i++) begin
      WR_DATA = 8'(i);
      step();
      check($sformatf("fill_level_%0d", i), 32'(LEVEL), 32'(i + 1));
      check($sformatf("fill_af_%0d", i), 32'(ALMOST_FULL), 32'(i + 1 >= 28));
      check($sformatf("fill_full_%0d", i), 32'(FULL), 32'(i + 1 == 32));
    end
    check("fill_no_ovf", 32'(OVERFLOW), 0);
    WR_DATA = 8'hAA;
    step();
    WR_EN = 1'b0;
    check("ovf_set", 32'(OVERFLOW), 1);
    check("ovf_level", 32'(LEVEL), 32);
    check("ovf_head", 32'(RD_DATA), 0);
    RD_EN = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("drain_%0d", i), 32'(RD_DATA), 32'(i));
      step();
    end
    RD_EN = 1'b0;
    check("drain_empty", 32'(EMPTY), 1);
    check("drain_ovf_sticky", 32'(OVERFLOW), 1);
    do_reset();
    check("reset_clears_ovf", 32'(OVERFLOW), 0);

    // Simultaneous read/write at steady level 5.
    for (int i = 1; i <= 5; i++) write_word(8'(i));
    check("lvl5", 32'(LEVEL), 5);
    WR_EN = 1'b1; RD_EN = 1'b1; WR_DATA = 8'h06;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("rw_data_%0d", i), 32'(RD_DATA), 32'(i));
      step();
      check($sformatf("rw_level_%0d", i), 32'(LEVEL), 5);
    end
    WR_EN = 1'b0;
    check("rw_head5", 32'(RD_DATA), 32'h05);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rw_drain_%0d", i), 32'(RD_DATA), (i == 0) ? 32'h05 : 32'h06);
      step();
    end
    RD_EN = 1'b0;
    check("rw_empty", 32'(EMPTY), 1);

    // Read+write while empty: write only.
    WR_EN = 1'b1; RD_EN = 1'b1; WR_DATA = 8'h77;
    step();
    WR_EN = 1'b0; RD_EN = 1'b0;
    check("e_unf", 32'(UNDERFLOW), 1);
    check("e_level", 32'(LEVEL), 1);
    check("e_rdata", 32'(RD_DATA), 32'h77);

    // Read+write while full: read only.
    for (int i = 0; i < 31; i++) write_word(8'(8'h40 + i));
    check("f_full", 32'(FULL), 1);
    check("f_no_ovf", 32'(OVERFLOW), 0);
    WR_EN = 1'b1; RD_EN = 1'b1; WR_DATA = 8'hEE;
    step();
    WR_EN = 1'b0;
    check("f_ovf", 32'(OVERFLOW), 1);
    check("f_level", 32'(LEVEL), 31);
    check("f_not_full", 32'(FULL), 0);
    for (int i = 0; i < 31; i++) begin
      check($sformatf("f_drain_%0d", i), 32'(RD_DATA), 32'(8'h40 + i));
      step();
    end
    RD_EN = 1'b0;
    check("f_drain_empty", 32'(EMPTY), 1);
    check("f_drain_rdata0", 32'(RD_DATA), 0);

    // Mid-stream reset with a write request held high.
    for (int i = 0; i < 10; i++) write_word(8'(8'h80 + i));
    check("m_level10", 32'(LEVEL), 10);
    RST = 1'b1; WR_EN = 1'b1; WR_DATA = 8'hC3;
    step();
    RST = 1'b0; WR_EN = 1'b0;
    check("m_level", 32'(LEVEL), 0);
    check("m_empty", 32'(EMPTY), 1);
    check("m_ovf", 32'(OVERFLOW), 0);
    check("m_unf", 32'(UNDERFLOW), 0);
    check("m_rdata", 32'(RD_DATA), 0);
    write_word(8'h5A);
    check("m_first", 32'(RD_DATA), 32'h5A);
    check("m_first_level", 32'(LEVEL), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/srl_fifo_reader.md
Name: srl_fifo_reader

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO built on addressable shift-register storage (SRL-style: shift-in only, read by address).
- Owns the read side: occupancy count, read-address generation, FULL/EMPTY/ALMOST_FULL flags and sticky error flags around a DEPTH x WIDTH shift array.
- Used as a shallow elastic buffer between pipeline stages inside Xilinx-targeted designs simulated under Verilator.

Parameters:
- WIDTH, 8, data word width in bits (1..64).
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W (default 32, legal 2..6).
- AF_THRESH, 28, ALMOST_FULL asserts when level >= AF_THRESH (1..DEPTH).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous active-high reset.
- WR_EN  input  1  write request.
- WR_DATA  input  WIDTH  write data.
- FULL  output  1  FIFO holds DEPTH words.
- ALMOST_FULL  output  1  level >= AF_THRESH.
- RD_EN  input  1  read request (pops head word).
- RD_DATA  output  WIDTH  head (oldest) word, FWFT.
- EMPTY  output  1  FIFO holds no words.
- LEVEL  output  ADDR_W+1  current occupancy, 0..DEPTH.
- OVERFLOW  output  1  sticky: write attempted while FULL.
- UNDERFLOW  output  1  sticky: read attempted while EMPTY.

Behaviour:
- Interface decided: one clock CLK; reset RST is synchronous and active-high.
- Storage: DEPTH-entry shift array, no reset, powers up all-zero. On accepted write, entry 0 <= WR_DATA and entry i <= entry i-1. Contents never move on reads.
- Accept rules:
  - wr_acc = WR_EN & ~FULL.
  - rd_acc = RD_EN & ~EMPTY.
  - Flags are registered state, so acceptance uses pre-edge values.
- Count register cnt (ADDR_W+1 bits), updated per edge:
  - +1 if wr_acc & ~rd_acc.
  - -1 if rd_acc & ~wr_acc.
  - unchanged if both or neither.
- Read address: cnt-1, i.e. the oldest entry.
  - RD_DATA = array[cnt-1] when cnt != 0.
  - RD_DATA = 0 when cnt == 0.
  - Combinational from the array and cnt; no extra register stage.
- Flags, all functions of cnt only:
  - EMPTY = (cnt == 0).
  - FULL = (cnt == DEPTH).
  - ALMOST_FULL = (cnt >= AF_THRESH).
  - LEVEL = cnt.
- Latency:
  - Write accepted at edge N: EMPTY deasserts and RD_DATA shows the word after edge N, so it is readable in cycle N+1.
  - Read accepted at edge N: RD_DATA shows the next word after edge N.
- Simultaneous read and write:
  - Non-empty, non-full: both accepted, cnt unchanged. The shift moves the head one address higher and the read address is unchanged, so the next-oldest word appears at RD_DATA.
  - EMPTY: only the write is accepted. UNDERFLOW sets; cnt becomes 1.
  - FULL: only the read is accepted. OVERFLOW sets; cnt becomes DEPTH-1.
- Rejected writes leave array and cnt untouched. Rejected reads leave cnt untouched.
- Sticky flags: OVERFLOW sets on WR_EN & FULL; UNDERFLOW sets on RD_EN & EMPTY. Both clear only on RST.
- Reset: while RST is high at an edge:
  - cnt <= 0, OVERFLOW <= 0, UNDERFLOW <= 0.
  - WR_EN and RD_EN are ignored and the array does not shift.
  - Outputs after the reset edge: EMPTY=1, FULL=0, ALMOST_FULL=0 (AF_THRESH >= 1), LEVEL=0, RD_DATA=0.
  - Array contents are not cleared, but they are unreachable.
  - Reset mid-stream discards all words; no partial state survives.
- No combinational path from WR_EN/RD_EN to any output.

Test Plan:
- Reset then idle 5 cycles -> EMPTY=1, FULL=0, LEVEL=0, RD_DATA=0, both sticky flags 0.
- Write 0x11,0x22,0x33 on consecutive cycles, then RD_EN 3 cycles:
  - RD_DATA shows 0x11 the cycle after the first write.
  - Reads return 0x11, 0x22, 0x33; LEVEL goes 3,2,1,0; EMPTY=1 at the end.
- Write 32 words 0x00..0x1F:
  - ALMOST_FULL rises when LEVEL reaches 28; FULL=1 at LEVEL=32.
  - Extra write 0xAA -> OVERFLOW=1, LEVEL stays 32.
  - Drain returns 0x00..0x1F in order with no 0xAA.
- LEVEL=5 (words 0x01..0x05), WR_EN+RD_EN with 0x06 for 4 cycles -> LEVEL stays 5, reads return 0x01..0x04, RD_DATA then shows 0x05.
- Boundary simultaneous events:
  - EMPTY with RD_EN+WR_EN (0x77) -> UNDERFLOW=1, LEVEL=1, RD_DATA=0x77.
  - FULL with RD_EN+WR_EN -> OVERFLOW=1, LEVEL=31, written word absent on drain.
- Fill to 10 words, assert RST one cycle with WR_EN=1 -> LEVEL=0, EMPTY=1, flags cleared. A subsequent write of 0x5A reads back 0x5A as the first word.
